// File: rtl/flexbyte_stp_packer_if.sv
// Handshake bundle for flexbyte_stp_packer: a word-wide input stream and a
// block-wide output stream, each with valid/ready flow control.
// The packer uses the slave modport and the traffic source/sink uses master.
interface flexbyte_stp_packer_if #(
  parameter int NUM_BYTES_IN  = 4,
  parameter int NUM_BYTES_OUT = 16
);
  localparam int WORDS = NUM_BYTES_OUT / NUM_BYTES_IN;
  localparam int CW    = $clog2(WORDS + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_BYTES_IN*8-1:0]  in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_BYTES_OUT*8-1:0] out_data;
  logic [CW-1:0]              out_words;
  logic                       out_partial;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_words, out_partial
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_words, out_partial
  );
endinterface

// File: rtl/flexbyte_stp_packer.sv
// Byte-oriented serial-to-parallel packer. Words of NUM_BYTES_IN bytes are
// shifted into an accumulator until WORDS of them form a block, or until a
// word flagged in_last closes a short block early. A completed block moves to
// a one-deep output register so the next block can fill while it waits.
// Short blocks are re-aligned so the first word sits in its nominal slot;
// the vacated slots are padded.
// Optional build macro: FLEXBYTE_STP_PAD_EN - pad bytes carry the PKCS#7
// value (number of pad bytes, mod 256) instead of 0x00.
module flexbyte_stp_packer #(
  parameter int MSB           = 1,
  parameter int NUM_BYTES_IN  = 4,
  parameter int NUM_BYTES_OUT = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  flexbyte_stp_packer_if.slave    bus
);
  localparam int IW    = NUM_BYTES_IN * 8;
  localparam int W     = NUM_BYTES_OUT * 8;
  localparam int WORDS = NUM_BYTES_OUT / NUM_BYTES_IN;
  localparam int CW    = $clog2(WORDS + 1);

  if ((NUM_BYTES_OUT <= NUM_BYTES_IN) || ((NUM_BYTES_OUT % NUM_BYTES_IN) != 0)) begin : g_bad_cfg
    $fatal(1, "flexbyte_stp_packer: NUM_BYTES_OUT must be a larger multiple of NUM_BYTES_IN");
  end

  typedef enum logic {FILL = 1'b0, STALL = 1'b1} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   acc_reg, acc_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [W-1:0]   out_data_reg, out_data_next;
  logic [CW-1:0]  out_words_reg, out_words_next;
  logic           out_partial_reg, out_partial_next;
  logic           out_valid_reg, out_valid_next;
  // word count and partial flag of a block parked in the accumulator
  logic [CW-1:0]  hold_words_reg, hold_words_next;
  logic           hold_partial_reg, hold_partial_next;

  logic           in_ready_int;
  logic           accept;
  logic           complete;
  logic           out_free;
  logic [CW-1:0]  n_words;
  logic [CW-1:0]  gap_words;
  logic [W-1:0]   shifted;
  logic [W-1:0]   aligned_raw;
  logic [W-1:0]   pad_fill;
  logic [W-1:0]   aligned;
  int             shift_amt;

  assign in_ready_int = (state_reg == FILL);
  assign accept       = bus.in_valid & in_ready_int & ~clear;
  assign n_words      = count_reg + CW'(1);
  assign gap_words    = CW'(WORDS) - n_words;
  assign complete     = accept & ((n_words == CW'(WORDS)) | bus.in_last);
  assign out_free     = ~out_valid_reg | bus.out_ready;

  // accumulator after taking the current word, in arrival order
  if (MSB != 0) begin : g_shift_msb
    assign shifted = {acc_reg[W-IW-1:0], bus.in_data};
  end else begin : g_shift_lsb
    assign shifted = {bus.in_data, acc_reg[W-1:IW]};
  end

  // move a short block so its first word lands in the nominal slot
  always_comb begin
    shift_amt = int'(gap_words) * IW;
    if (MSB != 0) aligned_raw = shifted << shift_amt;
    else          aligned_raw = shifted >> shift_amt;
  end

`ifdef FLEXBYTE_STP_PAD_EN
  logic [WORDS-1:0] pad_slot;
  logic [7:0]       pad_byte;

  assign pad_byte = 8'(int'(gap_words) * NUM_BYTES_IN);

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_pad
    // slots left empty by the re-alignment shift
    if (MSB != 0) begin : g_low
      assign pad_slot[gi] = (CW'(gi) < gap_words);
    end else begin : g_high
      assign pad_slot[gi] = (CW'(gi) >= n_words);
    end
    assign pad_fill[gi*IW +: IW] = pad_slot[gi] ? {NUM_BYTES_IN{pad_byte}} : '0;
  end
`else
  assign pad_fill = '0;
`endif

  assign aligned = aligned_raw | pad_fill;

  // next-state and datapath decisions; clear overrides every handshake
  always_comb begin
    state_next        = state_reg;
    acc_next          = acc_reg;
    count_next        = count_reg;
    out_data_next     = out_data_reg;
    out_words_next    = out_words_reg;
    out_partial_next  = out_partial_reg;
    out_valid_next    = out_valid_reg;
    hold_words_next   = hold_words_reg;
    hold_partial_next = hold_partial_reg;

    if (clear) begin
      state_next        = FILL;
      acc_next          = '0;
      count_next        = '0;
      out_data_next     = '0;
      out_words_next    = '0;
      out_partial_next  = 1'b0;
      out_valid_next    = 1'b0;
      hold_words_next   = '0;
      hold_partial_next = 1'b0;
    end else begin
      if (out_valid_reg && bus.out_ready) begin
        out_valid_next = 1'b0;
      end

      case (state_reg)
        FILL: begin
          if (accept) begin
            if (complete) begin
              count_next = '0;
              if (out_free) begin
                out_data_next    = aligned;
                out_words_next   = n_words;
                out_partial_next = (n_words != CW'(WORDS));
                out_valid_next   = 1'b1;
                acc_next         = '0;
              end else begin
                acc_next          = aligned;
                hold_words_next   = n_words;
                hold_partial_next = (n_words != CW'(WORDS));
                state_next        = STALL;
              end
            end else begin
              acc_next   = shifted;
              count_next = n_words;
            end
          end
        end

        STALL: begin
          if (out_free) begin
            out_data_next    = acc_reg;
            out_words_next   = hold_words_reg;
            out_partial_next = hold_partial_reg;
            out_valid_next   = 1'b1;
            acc_next         = '0;
            count_next       = '0;
            state_next       = FILL;
          end
        end

        default: state_next = FILL;
      endcase
    end
  end

  // state and data registers with asynchronous reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg        <= FILL;
      acc_reg          <= '0;
      count_reg        <= '0;
      out_data_reg     <= '0;
      out_words_reg    <= '0;
      out_partial_reg  <= 1'b0;
      out_valid_reg    <= 1'b0;
      hold_words_reg   <= '0;
      hold_partial_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      acc_reg          <= acc_next;
      count_reg        <= count_next;
      out_data_reg     <= out_data_next;
      out_words_reg    <= out_words_next;
      out_partial_reg  <= out_partial_next;
      out_valid_reg    <= out_valid_next;
      hold_words_reg   <= hold_words_next;
      hold_partial_reg <= hold_partial_next;
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_data    = out_data_reg;
  assign bus.out_words   = out_words_reg;
  assign bus.out_partial = out_partial_reg;
endmodule

// File: tb/tb_flexbyte_stp_packer.sv
// Testbench for flexbyte_stp_packer: an MSB=1 and an MSB=0 instance receive
// identical traffic. A block-level reference model queues each expected
// block when its closing word is accepted; a monitor pops and compares on
// every output consume.
module tb_flexbyte_stp_packer;
  localparam int NBI   = 4;
  localparam int NBO   = 16;
  localparam int IW    = NBI * 8;
  localparam int W     = NBO * 8;
  localparam int WORDS = NBO / NBI;

`ifdef FLEXBYTE_STP_PAD_EN
  localparam logic [W-1:0] PART_M = 128'hAABBCCDD_11223344_08080808_08080808;
  localparam logic [W-1:0] PART_L = 128'h08080808_08080808_11223344_AABBCCDD;
`else
  localparam logic [W-1:0] PART_M = 128'hAABBCCDD_11223344_00000000_00000000;
  localparam logic [W-1:0] PART_L = 128'h00000000_00000000_11223344_AABBCCDD;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic clear = 1'b0;

  flexbyte_stp_packer_if #(.NUM_BYTES_IN(NBI), .NUM_BYTES_OUT(NBO)) bus_m ();
  flexbyte_stp_packer_if #(.NUM_BYTES_IN(NBI), .NUM_BYTES_OUT(NBO)) bus_l ();

  flexbyte_stp_packer #(.MSB(1), .NUM_BYTES_IN(NBI), .NUM_BYTES_OUT(NBO)) dut_m (
    .clk(clk), .n_rst(n_rst), .clear(clear), .bus(bus_m)
  );
  flexbyte_stp_packer #(.MSB(0), .NUM_BYTES_IN(NBI), .NUM_BYTES_OUT(NBO)) dut_l (
    .clk(clk), .n_rst(n_rst), .clear(clear), .bus(bus_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           words;
    bit           partial;
  } exp_t;

  exp_t          q_m[$];
  exp_t          q_l[$];
  logic [IW-1:0] cur_words[WORDS];
  int            cur_n = 0;
  int            checks = 0;
  int            errors = 0;
  bit            rdy_rand = 1'b0;
  bit            rdy_val = 1'b1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pad_value(input int n);
`ifdef FLEXBYTE_STP_PAD_EN
    return 8'((WORDS - n) * NBI);
`else
    return 8'h00;
`endif
  endfunction

  // word k of the message goes to slot WORDS-1-k (msb) or slot k (lsb);
  // slots with no word get pad bytes
  function automatic logic [W-1:0] model_block(input bit msb, input int n);
    logic [W-1:0] b;
    b = '0;
    for (int s = 0; s < WORDS; s++) begin
      int k;
      k = msb ? (WORDS - 1 - s) : s;
      if (k < n) b[s*IW +: IW] = cur_words[k];
      else       b[s*IW +: IW] = {NBI{pad_value(n)}};
    end
    return b;
  endfunction

  task automatic model_accept(input logic [IW-1:0] d, input bit last);
    exp_t e;
    cur_words[cur_n] = d;
    cur_n++;
    if (cur_n == WORDS || last) begin
      e.words   = cur_n;
      e.partial = (cur_n != WORDS);
      e.data    = model_block(1'b1, cur_n);
      q_m.push_back(e);
      e.data    = model_block(1'b0, cur_n);
      q_l.push_back(e);
      cur_n = 0;
    end
  endtask

  task automatic model_flush();
    cur_n = 0;
    q_m.delete();
    q_l.delete();
  endtask

  // consumer: out_ready changes 2 time units after the rising edge
  always @(posedge clk) begin
    #2;
    if (rdy_rand) bus_m.out_ready = ($urandom_range(0, 3) != 0);
    else          bus_m.out_ready = rdy_val;
    bus_l.out_ready = bus_m.out_ready;
  end

  // monitor: every consumed block is compared against the scoreboard head
  always @(negedge clk) begin : monitor
    exp_t e;
    if (n_rst && !clear && bus_m.out_valid && bus_m.out_ready) begin
      if (q_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL msb_unexpected: actual=%h required=no block", bus_m.out_data);
      end else begin
        e = q_m.pop_front();
        check("msb_data", bus_m.out_data, e.data);
        check("msb_words", W'(bus_m.out_words), W'(e.words));
        check("msb_partial", W'(bus_m.out_partial), W'(e.partial));
      end
    end
    if (n_rst && !clear && bus_l.out_valid && bus_l.out_ready) begin
      if (q_l.size() == 0) begin
        checks++; errors++;
        $display("FAIL lsb_unexpected: actual=%h required=no block", bus_l.out_data);
      end else begin
        e = q_l.pop_front();
        check("lsb_data", bus_l.out_data, e.data);
        check("lsb_words", W'(bus_l.out_words), W'(e.words));
        check("lsb_partial", W'(bus_l.out_partial), W'(e.partial));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input bit v, input logic [IW-1:0] d, input bit last);
    bus_m.in_valid = v; bus_l.in_valid = v;
    bus_m.in_data  = d; bus_l.in_data  = d;
    bus_m.in_last  = last; bus_l.in_last = last;
  endtask

  // present one word and hold it until accepted; returns 1 after the accepting edge
  task automatic send_word(input logic [IW-1:0] d, input bit last);
    int guard;
    guard = 0;
    drive_in(1'b1, d, last);
    @(negedge clk);
    while (!bus_m.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: actual=0 required=1 within 200 cycles");
    end else begin
      model_accept(d, last);
    end
    step();
    drive_in(1'b0, '0, 1'b0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    drive_in(1'b1, $urandom, 1'b0);
    step();
    clear = 1'b0;
    drive_in(1'b0, '0, 1'b0);
    model_flush();
  endtask

  task automatic set_ready(input bit v);
    rdy_val = v;
    step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_valid"}, W'(bus_m.out_valid), '0);
    check({tag, "_m_data"}, bus_m.out_data, '0);
    check({tag, "_m_words"}, W'(bus_m.out_words), '0);
    check({tag, "_m_partial"}, W'(bus_m.out_partial), '0);
    check({tag, "_l_valid"}, W'(bus_l.out_valid), '0);
    check({tag, "_l_data"}, bus_l.out_data, '0);
  endtask

  initial begin
    drive_in(1'b0, '0, 1'b0);
    bus_m.out_ready = 1'b1;
    bus_l.out_ready = 1'b1;

    // reset state
    #2 n_rst = 1'b0;
    #1;
    check_outputs_zero("reset");
    check("reset_in_ready", W'(bus_m.in_ready), W'(1));
    #19 n_rst = 1'b1;
    step();

    // four words, out_ready high: block visible one clock after the 4th accept
    send_word(32'h00010203, 1'b0);
    send_word(32'h04050607, 1'b0);
    send_word(32'h08090A0B, 1'b0);
    send_word(32'h0C0D0E0F, 1'b0);
    @(negedge clk);
    check("t1_m_valid", W'(bus_m.out_valid), W'(1));
    check("t1_m_data", bus_m.out_data, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    check("t1_l_data", bus_l.out_data, 128'h0C0D0E0F_08090A0B_04050607_00010203);
    check("t1_m_words", W'(bus_m.out_words), W'(4));
    check("t1_m_partial", W'(bus_m.out_partial), '0);
    repeat (3) step();

    // eight words into a stalled consumer, then drain two blocks back to back
    set_ready(1'b0);
    for (int i = 0; i < 8; i++) send_word($urandom, 1'b0);
    @(negedge clk);
    check("stall_in_ready", W'(bus_m.in_ready), '0);
    check("stall_held_valid", W'(bus_m.out_valid), W'(1));
    set_ready(1'b1);
    @(negedge clk);
    check("drain_blk1_valid", W'(bus_m.out_valid), W'(1));
    step();
    @(negedge clk);
    check("drain_blk2_valid", W'(bus_m.out_valid), W'(1));
    check("drain_in_ready", W'(bus_m.in_ready), W'(1));
    repeat (3) step();

    // short block closed by in_last
    send_word(32'hAABBCCDD, 1'b0);
    send_word(32'h11223344, 1'b1);
    @(negedge clk);
    check("part_m_data", bus_m.out_data, PART_M);
    check("part_l_data", bus_l.out_data, PART_L);
    check("part_m_words", W'(bus_m.out_words), W'(2));
    check("part_m_partial", W'(bus_m.out_partial), W'(1));
    repeat (3) step();

    // clear after three words discards them and blocks the pending word
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
    pulse_clear();
    @(negedge clk);
    check("clear_valid", W'(bus_m.out_valid), '0);
    step();
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
    repeat (3) step();

    // reset while a block is held and another is part-filled
    set_ready(1'b0);
    for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    model_flush();
    @(negedge clk);
    #2 n_rst = 1'b1;
    set_ready(1'b1);
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
    @(negedge clk);
    check("post_rst_valid", W'(bus_m.out_valid), W'(1));
    step();

    // random traffic with gaps, random in_last, random back-pressure, rare clears
    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      if ($urandom_range(0, 79) == 0) pulse_clear();
      else send_word($urandom, ($urandom_range(0, 4) == 0));
    end

    // drain everything still expected
    rdy_rand = 1'b0;
    set_ready(1'b1);
    for (int g = 0; g < 500 && (q_m.size() != 0 || q_l.size() != 0); g++) step();
    if (q_m.size() != 0 || q_l.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: actual=%0d/%0d blocks pending required=0", q_m.size(), q_l.size());
    end
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flexbyte_stp_packer.md
Name: flexbyte_stp_packer

Overview:
Parametrised byte-oriented serial-to-parallel packer with valid/ready handshakes on both sides. It accumulates NUM_BYTES_IN-byte words into NUM_BYTES_OUT-byte blocks, for example 32-bit bus words into 128-bit AES state blocks. A one-block output holding register lets the next block fill while the previous one waits for the cipher core. A last-word marker closes short blocks early with padding and reports the valid word count.

Parameters:
MSB, 1, 1 = first accepted word lands in the most-significant slot; 0 = first word lands in the least-significant slot
NUM_BYTES_IN, 4, bytes per input word
NUM_BYTES_OUT, 16, bytes per output block
- Elaboration-time fatal unless NUM_BYTES_OUT > NUM_BYTES_IN and NUM_BYTES_OUT % NUM_BYTES_IN == 0.
- Derived: WORDS = NUM_BYTES_OUT/NUM_BYTES_IN; CW = $clog2(WORDS+1).

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush; highest priority
in_valid  in  1  input word valid
in_ready  out  1  packer can accept a word
in_data  in  NUM_BYTES_IN*8  input word
in_last  in  1  qualifies in_data as the final word of the message
out_valid  out  1  output block valid
out_ready  in  1  consumer accepts the block
out_data  out  NUM_BYTES_OUT*8  packed block
out_words  out  CW  number of valid words in out_data (1..WORDS)
out_partial  out  1  block was closed early by in_last

Behaviour:
- Reset: accumulator=0, count=0, state=FILL, out_data=0, out_valid=0, out_words=0, out_partial=0.
- Handshakes:
  - Input word accepted when in_valid & in_ready.
  - Output block consumed when out_valid & out_ready.
  - out_data, out_words and out_partial hold stable while out_valid & !out_ready.
- Shifting on each accepted word:
  - MSB=1: acc = (acc << 8*NUM_BYTES_IN) | in_data.
  - MSB=0: acc = (acc >> 8*NUM_BYTES_IN) with in_data placed in the top slot.
  - count increments.
- Block completion: an accepted word completes the block when count+1 == WORDS or in_last=1.
- Partial alignment: a block closed at n < WORDS words is shifted by (WORDS-n) word slots so the first word sits in its nominal slot.
  - MSB=1: shift left, pad in the low slots.
  - MSB=0: shift right, pad in the high slots.
  - Pad bytes are 0x00.
- States:
  - FILL: in_ready=1.
    - On completion with the output register free (!out_valid, or out_valid & out_ready in the same cycle): the completed block loads into the output register at that same edge, out_valid=1 after that edge (latency 1 clock from accept), count=0, stay in FILL.
    - On completion with the output register occupied and not draining: the completed block stays in the accumulator; go to STALL.
  - STALL: in_ready=0.
    - When the output register is free: the accumulator block transfers to the output register, count=0, go to FILL.
- out_valid clears on consume unless a new block loads in the same cycle, in which case it stays 1 with the new data.
- in_last on the WORDS-th word gives a normal full block with out_partial=0. No extra block is generated.
- in_last alone never produces an empty block; the marker only applies to accepted words.
- clear: next edge gives count=0, accumulator=0, out_valid=0, state=FILL. Any pending in_valid or out_ready in that cycle is ignored: no accept, no consume.
- n_rst asserted mid-block: all state returns to reset values immediately. Partial data is discarded.
- Throughput: one word per clock sustained when out_ready=1. No bubble between blocks.

Optional Feature:
- Macro: FLEXBYTE_STP_PAD_EN.
- Defined: pad bytes of a partial block carry the PKCS#7 value P = (WORDS-n)*NUM_BYTES_IN, mod 256, instead of 0x00. Full blocks are unchanged.
- Undefined: pad bytes are 0x00. Logic for the pad value is absent.

Test Plan:
- Default parameters, out_ready=1, words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F on consecutive clocks -> out_valid the clock after the 4th accept; out_data=0x000102030405060708090A0B0C0D0E0F; out_words=4; out_partial=0.
- MSB=0, same stimulus -> out_data=0x0C0D0E0F08090A0B0405060700010203.
- out_ready=0, 8 back-to-back words -> block 1 held; in_ready falls after the 8th accept (STALL). Raise out_ready -> block 1 then block 2 delivered on consecutive clocks; no word lost or reordered.
- Words 0xAABBCCDD, then 0x11223344 with in_last -> out_data=0xAABBCCDD112233440000000000000000; out_words=2; out_partial=1. With FLEXBYTE_STP_PAD_EN, pad bytes are 0x08.
- After 3 accepted words, pulse clear with out_ready=1 and in_valid=1 -> that word is not accepted; out_valid stays 0; the next 4 words form a clean block.
- Assert n_rst mid-block and while out_valid=1 -> all outputs 0 immediately; the first block after release is correct.
